// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - in-order dispatch queue with credit gating and a register readiness scoreboard
// Optional stall counters are built when DISPATCH_PERF_CNT_EN is defined; otherwise perf_stall_* read 0.
module dispatch_queue #(
  parameter int DISPATCH_W = 2,
  parameter int QDEPTH     = 8,
  parameter int PREGS      = 64,
  parameter int CDB_W      = 2,
  parameter int MEM_PORTS  = 1,
  parameter int PAYLOAD_W  = 96,
  parameter int PHYS_W     = $clog2(PREGS),
  parameter int CW         = $clog2(DISPATCH_W + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic [DISPATCH_W-1:0]                 in_valid,
  output logic                                  in_ready,
  input  logic [DISPATCH_W-1:0][PHYS_W-1:0]     in_prs1,
  input  logic [DISPATCH_W-1:0][PHYS_W-1:0]     in_prs2,
  input  logic [DISPATCH_W-1:0][PHYS_W-1:0]     in_prd,
  input  logic [DISPATCH_W-1:0]                 in_rs1_v,
  input  logic [DISPATCH_W-1:0]                 in_rs2_v,
  input  logic [DISPATCH_W-1:0]                 in_rd_v,
  input  logic [DISPATCH_W-1:0]                 in_is_mem,
  input  logic [DISPATCH_W-1:0][PAYLOAD_W-1:0]  in_payload,
  input  logic [CW-1:0]                         rob_credit,
  input  logic [CW-1:0]                         rs_credit,
  input  logic [CW-1:0]                         lsq_credit,
  input  logic [CDB_W-1:0]                      cdb_valid,
  input  logic [CDB_W-1:0][PHYS_W-1:0]          cdb_tag,
  output logic [DISPATCH_W-1:0]                 out_valid,
  output logic [DISPATCH_W-1:0]                 out_is_mem,
  output logic [DISPATCH_W-1:0][PHYS_W-1:0]     out_prs1,
  output logic [DISPATCH_W-1:0][PHYS_W-1:0]     out_prs2,
  output logic [DISPATCH_W-1:0][PHYS_W-1:0]     out_prd,
  output logic [DISPATCH_W-1:0]                 out_rd_v,
  output logic [DISPATCH_W-1:0][PAYLOAD_W-1:0]  out_payload,
  output logic [DISPATCH_W-1:0]                 out_src1_rdy,
  output logic [DISPATCH_W-1:0]                 out_src2_rdy,
  output logic [31:0]                           perf_stall_rob,
  output logic [31:0]                           perf_stall_rs,
  output logic [31:0]                           perf_stall_lsq,
  output logic [31:0]                           perf_stall_mem
);

  localparam int IDX_W = $clog2(QDEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int UW    = CW + 1;

  logic [PHYS_W-1:0]    q_prs1    [QDEPTH];
  logic [PHYS_W-1:0]    q_prs2    [QDEPTH];
  logic [PHYS_W-1:0]    q_prd     [QDEPTH];
  logic                 q_rs1_v   [QDEPTH];
  logic                 q_rs2_v   [QDEPTH];
  logic                 q_rd_v    [QDEPTH];
  logic                 q_is_mem  [QDEPTH];
  logic [PAYLOAD_W-1:0] q_payload [QDEPTH];

  logic [PTR_W-1:0] head, tail, count;
  logic [PTR_W-1:0] enq_n, deq_n;
  logic [IDX_W-1:0] wr_idx [DISPATCH_W];
  logic [IDX_W-1:0] rd_idx [DISPATCH_W];

  logic [DISPATCH_W-1:0][PHYS_W-1:0]    h_prs1, h_prs2, h_prd;
  logic [DISPATCH_W-1:0]                h_rs1_v, h_rs2_v, h_rd_v, h_is_mem;
  logic [DISPATCH_W-1:0][PAYLOAD_W-1:0] h_payload;

  logic [DISPATCH_W-1:0] disp;
  logic [DISPATCH_W-1:0] src1_rdy, src2_rdy;
  logic                  sel_stop;
  logic [UW-1:0]         rob_use, rs_use, lsq_use;
  logic                  stall_rob, stall_rs, stall_lsq, stall_mem;

  logic [PREGS-1:0] scoreboard, sb_next;

  // in_ready looks only at the registered count, so a full queue stays closed even while it drains.
  assign in_ready = !reset && !flush &&
                    ((PTR_W'(QDEPTH) - count) >= PTR_W'(DISPATCH_W));

  always_comb begin
    enq_n = '0;
    for (int j = 0; j < DISPATCH_W; j++) begin
      if (in_valid[j]) enq_n = enq_n + PTR_W'(1);
      wr_idx[j] = tail[IDX_W-1:0] + IDX_W'(j);
      rd_idx[j] = head[IDX_W-1:0] + IDX_W'(j);
    end
    if (!in_ready) enq_n = '0;
  end

  always_ff @(posedge clk) begin
    if (in_ready) begin
      for (int j = 0; j < DISPATCH_W; j++) begin
        if (in_valid[j]) begin
          q_prs1[wr_idx[j]]    <= in_prs1[j];
          q_prs2[wr_idx[j]]    <= in_prs2[j];
          q_prd[wr_idx[j]]     <= in_prd[j];
          q_rs1_v[wr_idx[j]]   <= in_rs1_v[j];
          q_rs2_v[wr_idx[j]]   <= in_rs2_v[j];
          q_rd_v[wr_idx[j]]    <= in_rd_v[j];
          q_is_mem[wr_idx[j]]  <= in_is_mem[j];
          q_payload[wr_idx[j]] <= in_payload[j];
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < DISPATCH_W; j++) begin
      h_prs1[j]    = q_prs1[rd_idx[j]];
      h_prs2[j]    = q_prs2[rd_idx[j]];
      h_prd[j]     = q_prd[rd_idx[j]];
      h_rs1_v[j]   = q_rs1_v[rd_idx[j]];
      h_rs2_v[j]   = q_rs2_v[rd_idx[j]];
      h_rd_v[j]    = q_rd_v[rd_idx[j]];
      h_is_mem[j]  = q_is_mem[rd_idx[j]];
      h_payload[j] = q_payload[rd_idx[j]];
    end
  end

  // In-order scan from head; the first entry that misses a credit ends the group and names the stall.
  always_comb begin
    sel_stop  = 1'b0;
    rob_use   = '0;
    rs_use    = '0;
    lsq_use   = '0;
    deq_n     = '0;
    disp      = '0;
    stall_rob = 1'b0;
    stall_rs  = 1'b0;
    stall_lsq = 1'b0;
    stall_mem = 1'b0;
    for (int j = 0; j < DISPATCH_W; j++) begin
      if (!sel_stop) begin
        if (PTR_W'(j) >= count) begin
          sel_stop = 1'b1;
        end else begin
          rob_use = rob_use + UW'(1);
          rs_use  = rs_use  + UW'(!h_is_mem[j]);
          lsq_use = lsq_use + UW'(h_is_mem[j]);
          if (rob_use > {1'b0, rob_credit}) begin
            sel_stop  = 1'b1;
            stall_rob = 1'b1;
          end else if (rs_use > {1'b0, rs_credit}) begin
            sel_stop = 1'b1;
            stall_rs = 1'b1;
          end else if (lsq_use > {1'b0, lsq_credit}) begin
            sel_stop  = 1'b1;
            stall_lsq = 1'b1;
          end else if (lsq_use > UW'(MEM_PORTS)) begin
            sel_stop  = 1'b1;
            stall_mem = 1'b1;
          end else begin
            disp[j] = 1'b1;
            deq_n   = deq_n + PTR_W'(1);
          end
        end
      end
    end
    if (reset || flush) begin
      disp      = '0;
      deq_n     = '0;
      stall_rob = 1'b0;
      stall_rs  = 1'b0;
      stall_lsq = 1'b0;
      stall_mem = 1'b0;
    end
  end

  // Tag 0 and unused sources are always ready; an older lane of the same group writing the tag overrides.
  always_comb begin
    for (int j = 0; j < DISPATCH_W; j++) begin
      src1_rdy[j] = !h_rs1_v[j] || (h_prs1[j] == '0) || scoreboard[h_prs1[j]];
      src2_rdy[j] = !h_rs2_v[j] || (h_prs2[j] == '0) || scoreboard[h_prs2[j]];
      for (int c = 0; c < CDB_W; c++) begin
        if (cdb_valid[c] && (cdb_tag[c] == h_prs1[j])) src1_rdy[j] = 1'b1;
        if (cdb_valid[c] && (cdb_tag[c] == h_prs2[j])) src2_rdy[j] = 1'b1;
      end
      for (int i = 0; i < j; i++) begin
        if (disp[i] && h_rd_v[i] && h_rs1_v[j] && (h_prs1[j] != '0) && (h_prd[i] == h_prs1[j]))
          src1_rdy[j] = 1'b0;
        if (disp[i] && h_rd_v[i] && h_rs2_v[j] && (h_prs2[j] != '0) && (h_prd[i] == h_prs2[j]))
          src2_rdy[j] = 1'b0;
      end
    end
  end

  always_comb begin
    sb_next = scoreboard;
    for (int c = 0; c < CDB_W; c++) begin
      if (cdb_valid[c]) sb_next[cdb_tag[c]] = 1'b1;
    end
    for (int j = 0; j < DISPATCH_W; j++) begin
      if (disp[j] && h_rd_v[j] && (h_prd[j] != '0)) sb_next[h_prd[j]] = 1'b0;
    end
    sb_next[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scoreboard <= '1;
    end else begin
      scoreboard <= sb_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + deq_n;
      tail  <= tail + enq_n;
      count <= count + enq_n - deq_n;
    end
  end

  always_comb begin
    out_valid    = disp;
    out_is_mem   = reset ? '0 : h_is_mem;
    out_prs1     = reset ? '0 : h_prs1;
    out_prs2     = reset ? '0 : h_prs2;
    out_prd      = reset ? '0 : h_prd;
    out_rd_v     = reset ? '0 : h_rd_v;
    out_payload  = reset ? '0 : h_payload;
    out_src1_rdy = reset ? '0 : src1_rdy;
    out_src2_rdy = reset ? '0 : src2_rdy;
  end

`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] cnt_rob, cnt_rs, cnt_lsq, cnt_mem;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_rob <= '0;
      cnt_rs  <= '0;
      cnt_lsq <= '0;
      cnt_mem <= '0;
    end else begin
      if (stall_rob && (cnt_rob != '1)) cnt_rob <= cnt_rob + 32'd1;
      if (stall_rs  && (cnt_rs  != '1)) cnt_rs  <= cnt_rs  + 32'd1;
      if (stall_lsq && (cnt_lsq != '1)) cnt_lsq <= cnt_lsq + 32'd1;
      if (stall_mem && (cnt_mem != '1)) cnt_mem <= cnt_mem + 32'd1;
    end
  end

  assign perf_stall_rob = cnt_rob;
  assign perf_stall_rs  = cnt_rs;
  assign perf_stall_lsq = cnt_lsq;
  assign perf_stall_mem = cnt_mem;
`else
  logic perf_unused;
  assign perf_unused    = ^{stall_rob, stall_rs, stall_lsq, stall_mem};
  assign perf_stall_rob = '0;
  assign perf_stall_rs  = '0;
  assign perf_stall_lsq = '0;
  assign perf_stall_mem = '0;
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// tb/tb_dispatch_queue.sv - directed self-checking bench for dispatch_queue
module tb_dispatch_queue;

  localparam int DW = 2;
  localparam int PW = 6;
  localparam int PLW = 96;

`ifdef DISPATCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, flush;
  logic [DW-1:0] in_valid;
  logic in_ready;
  logic [DW-1:0][PW-1:0] in_prs1, in_prs2, in_prd;
  logic [DW-1:0] in_rs1_v, in_rs2_v, in_rd_v, in_is_mem;
  logic [DW-1:0][PLW-1:0] in_payload;
  logic [1:0] rob_credit, rs_credit, lsq_credit;
  logic [1:0] cdb_valid;
  logic [1:0][PW-1:0] cdb_tag;
  logic [DW-1:0] out_valid, out_is_mem, out_rd_v, out_src1_rdy, out_src2_rdy;
  logic [DW-1:0][PW-1:0] out_prs1, out_prs2, out_prd;
  logic [DW-1:0][PLW-1:0] out_payload;
  logic [31:0] perf_stall_rob, perf_stall_rs, perf_stall_lsq, perf_stall_mem;

  int checks = 0;
  int errors = 0;

  dispatch_queue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_prs1(in_prs1), .in_prs2(in_prs2), .in_prd(in_prd),
    .in_rs1_v(in_rs1_v), .in_rs2_v(in_rs2_v), .in_rd_v(in_rd_v),
    .in_is_mem(in_is_mem), .in_payload(in_payload),
    .rob_credit(rob_credit), .rs_credit(rs_credit), .lsq_credit(lsq_credit),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .out_valid(out_valid), .out_is_mem(out_is_mem),
    .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd),
    .out_rd_v(out_rd_v), .out_payload(out_payload),
    .out_src1_rdy(out_src1_rdy), .out_src2_rdy(out_src2_rdy),
    .perf_stall_rob(perf_stall_rob), .perf_stall_rs(perf_stall_rs),
    .perf_stall_lsq(perf_stall_lsq), .perf_stall_mem(perf_stall_mem)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_lane(input int l, input logic [PW-1:0] prs1, input logic rs1v,
                          input logic [PW-1:0] prs2, input logic rs2v,
                          input logic [PW-1:0] prd, input logic rdv, input logic mem);
    in_prs1[l]    = prs1;
    in_rs1_v[l]   = rs1v;
    in_prs2[l]    = prs2;
    in_rs2_v[l]   = rs2v;
    in_prd[l]     = prd;
    in_rd_v[l]    = rdv;
    in_is_mem[l]  = mem;
    in_payload[l] = {32'hCAFE_0000 + 32'(prd), 32'(l), 32'hDEAD_BEEF};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 2'b11;
    rob_credit = 2'd2; rs_credit = 2'd2; lsq_credit = 2'd2;
    cdb_valid = '0; cdb_tag = '0;
    set_lane(0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd3, 1'b1, 1'b0);
    set_lane(1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd4, 1'b1, 1'b1);

    // reset held three cycles with lanes offered
    for (int i = 0; i < 3; i++) begin
      #1;
      expect_val("rst_out_valid", 64'(out_valid), 64'd0);
      expect_val("rst_in_ready", 64'(in_ready), 64'd0);
      expect_val("rst_out_prd", 64'(out_prd), 64'd0);
      if (i > 0) expect_val("rst_perf", 64'(perf_stall_rob | perf_stall_rs | perf_stall_lsq | perf_stall_mem), 64'd0);
      tick();
    end
    reset = 1'b0; in_valid = 2'b00;
    #1;
    expect_val("rel_in_ready", 64'(in_ready), 64'd1);
    expect_val("rel_out_valid", 64'(out_valid), 64'd0);
    expect_val("rel_scoreboard", dut.scoreboard, 64'hFFFF_FFFF_FFFF_FFFF);

    // basic flow
    tick();
    set_lane(0, 6'd1, 1'b1, 6'd0, 1'b0, 6'd5, 1'b1, 1'b0);
    set_lane(1, 6'd2, 1'b1, 6'd3, 1'b1, 6'd6, 1'b1, 1'b0);
    in_valid = 2'b11;
    #1;
    expect_val("basic_in_ready", 64'(in_ready), 64'd1);
    expect_val("basic_empty", 64'(out_valid), 64'd0);
    tick();
    in_valid = 2'b00;
    #1;
    expect_val("basic_out_valid", 64'(out_valid), 64'd3);
    expect_val("basic_prd0", 64'(out_prd[0]), 64'd5);
    expect_val("basic_prd1", 64'(out_prd[1]), 64'd6);
    expect_val("basic_src1", 64'(out_src1_rdy), 64'd3);
    expect_val("basic_src2", 64'(out_src2_rdy), 64'd3);
    expect_val("basic_pay_lo", out_payload[1][63:0], 64'h0000_0001_DEAD_BEEF);
    expect_val("basic_pay_hi", 64'(out_payload[1][95:64]), 64'hCAFE_0006);
    tick();
    #1;
    expect_val("basic_sb5", 64'(dut.scoreboard[5]), 64'd0);
    expect_val("basic_sb6", 64'(dut.scoreboard[6]), 64'd0);
    expect_val("basic_drained", 64'(out_valid), 64'd0);

    // intra-group RAW
    tick();
    set_lane(0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd7, 1'b1, 1'b0);
    set_lane(1, 6'd7, 1'b1, 6'd5, 1'b1, 6'd8, 1'b1, 1'b0);
    in_valid = 2'b11;
    tick();
    in_valid = 2'b00;
    #1;
    expect_val("raw_out_valid", 64'(out_valid), 64'd3);
    expect_val("raw_src1", 64'(out_src1_rdy), 64'd1);
    expect_val("raw_src2", 64'(out_src2_rdy), 64'd1);
    tick();
    #1;
    expect_val("raw_sb7_clr", 64'(dut.scoreboard[7]), 64'd0);
    tick();
    cdb_valid = 2'b10; cdb_tag[1] = 6'd7;
    tick();
    cdb_valid = 2'b00;
    #1;
    expect_val("raw_sb7_set", 64'(dut.scoreboard[7]), 64'd1);
    expect_val("raw_sb8", 64'(dut.scoreboard[8]), 64'd0);

    // CDB bypass at dispatch
    set_lane(0, 6'd8, 1'b1, 6'd5, 1'b1, 6'd0, 1'b0, 1'b0);
    in_valid = 2'b01;
    tick();
    in_valid = 2'b00;
    cdb_valid = 2'b01; cdb_tag[0] = 6'd8;
    #1;
    expect_val("byp_out_valid", 64'(out_valid), 64'd1);
    expect_val("byp_src1", 64'(out_src1_rdy[0]), 64'd1);
    expect_val("byp_src2", 64'(out_src2_rdy[0]), 64'd0);
    tick();
    cdb_valid = 2'b00;
    #1;
    expect_val("byp_sb8", 64'(dut.scoreboard[8]), 64'd1);

    // MEM_PORTS limit
    set_lane(0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1);
    set_lane(1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1);
    in_valid = 2'b11;
    tick();
    in_valid = 2'b00;
    #1;
    expect_val("mem_cyc1", 64'(out_valid), 64'd1);
    expect_val("mem_is_mem", 64'(out_is_mem[0]), 64'd1);
    tick();
    #1;
    expect_val("mem_cyc2", 64'(out_valid), 64'd1);
    expect_val("mem_perf", 64'(perf_stall_mem), PERF ? 64'd1 : 64'd0);
    tick();
    #1;
    expect_val("mem_empty", 64'(out_valid), 64'd0);

    // in-order RS credit stall
    set_lane(0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    set_lane(1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1);
    in_valid = 2'b11; rs_credit = 2'd0;
    tick();
    in_valid = 2'b00;
    #1;
    expect_val("rs_stall1", 64'(out_valid), 64'd0);
    tick();
    #1;
    expect_val("rs_stall2", 64'(out_valid), 64'd0);
    expect_val("rs_perf1", 64'(perf_stall_rs), PERF ? 64'd1 : 64'd0);
    tick();
    rs_credit = 2'd2;
    #1;
    expect_val("rs_release", 64'(out_valid), 64'd3);
    expect_val("rs_perf2", 64'(perf_stall_rs), PERF ? 64'd2 : 64'd0);
    tick();

    // fill to 7 with no ROB credit, then flush
    rob_credit = 2'd0;
    set_lane(0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    set_lane(1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    in_valid = 2'b01;
    #1;
    expect_val("fill_rdy_c0", 64'(in_ready), 64'd1);
    tick();
    in_valid = 2'b11;
    #1;
    expect_val("fill_rdy_c1", 64'(in_ready), 64'd1);
    tick();
    #1;
    expect_val("fill_rdy_c3", 64'(in_ready), 64'd1);
    tick();
    #1;
    expect_val("fill_rdy_c5", 64'(in_ready), 64'd1);
    tick();
    #1;
    expect_val("fill_rdy_c7", 64'(in_ready), 64'd0);
    expect_val("fill_no_disp", 64'(out_valid), 64'd0);
    tick();
    in_valid = 2'b00; flush = 1'b1; rob_credit = 2'd2;
    #1;
    expect_val("flush_in_ready", 64'(in_ready), 64'd0);
    expect_val("flush_out_valid", 64'(out_valid), 64'd0);
    expect_val("flush_perf_rob", 64'(perf_stall_rob), PERF ? 64'd4 : 64'd0);
    tick();
    flush = 1'b0;
    #1;
    expect_val("postflush_ready", 64'(in_ready), 64'd1);
    expect_val("postflush_empty", 64'(out_valid), 64'd0);
    expect_val("postflush_sb5", 64'(dut.scoreboard[5]), 64'd0);
    expect_val("postflush_sb7", 64'(dut.scoreboard[7]), 64'd1);
    expect_val("postflush_perf", 64'(perf_stall_rob), PERF ? 64'd4 : 64'd0);

    // partial ROB credit
    rob_credit = 2'd1;
    set_lane(0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd9, 1'b1, 1'b0);
    set_lane(1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd10, 1'b1, 1'b0);
    in_valid = 2'b11;
    tick();
    in_valid = 2'b00;
    #1;
    expect_val("rob1_valid", 64'(out_valid), 64'd1);
    expect_val("rob1_prd", 64'(out_prd[0]), 64'd9);
    tick();
    #1;
    expect_val("rob2_valid", 64'(out_valid), 64'd1);
    expect_val("rob2_prd", 64'(out_prd[0]), 64'd10);
    expect_val("rob2_sb9", 64'(dut.scoreboard[9]), 64'd0);
    expect_val("rob2_perf", 64'(perf_stall_rob), PERF ? 64'd5 : 64'd0);
    tick();
    rob_credit = 2'd2;

    // LSQ credit stall
    lsq_credit = 2'd0;
    set_lane(0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1);
    in_valid = 2'b01;
    tick();
    in_valid = 2'b00;
    #1;
    expect_val("lsq_stall", 64'(out_valid), 64'd0);
    tick();
    lsq_credit = 2'd2;
    #1;
    expect_val("lsq_release", 64'(out_valid), 64'd1);
    expect_val("lsq_perf", 64'(perf_stall_lsq), PERF ? 64'd1 : 64'd0);
    tick();

    // reset mid-operation discards queued entries
    set_lane(0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd11, 1'b1, 1'b0);
    set_lane(1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd12, 1'b1, 1'b0);
    in_valid = 2'b11;
    tick();
    in_valid = 2'b00; reset = 1'b1;
    #1;
    expect_val("midrst_out_valid", 64'(out_valid), 64'd0);
    expect_val("midrst_in_ready", 64'(in_ready), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    expect_val("midrst_rel_valid", 64'(out_valid), 64'd0);
    expect_val("midrst_rel_ready", 64'(in_ready), 64'd1);
    expect_val("midrst_sb", dut.scoreboard, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_val("midrst_perf", 64'(perf_stall_rob), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
